// File: rtl/l1_tlb_refill_pkg.sv
// Shared MMU definitions for the L1 TLB refill path: virtual address geometry,
// leaf PTE layout and the walker requester-id encoding.
package l1_tlb_refill_pkg;

  localparam int unsigned VADDR_SIZE = 39;
  localparam int unsigned TLB_OFFSET = 12;
  localparam int unsigned TLB_PN     = 3;
  localparam int unsigned VPN_WIDTH  = VADDR_SIZE - TLB_OFFSET;

  typedef logic [VPN_WIDTH-1:0] vpn_addr_t;

  typedef struct packed {
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_entry_t;

  typedef enum logic [1:0] {
    SRC_IFETCH = 2'd0,
    SRC_LOAD   = 2'd1,
    SRC_STORE  = 2'd2
  } src_e;

endpackage

// File: rtl/l1_tlb_refill_victim_sel.sv
// Victim chooser for an L1 TLB fill: the lowest invalid slot if one exists,
// otherwise a round-robin pointer that advances only when it was actually consumed.
module tlb_victim_sel #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] valid,
  input  logic             advance,
  output logic [AW-1:0]    idx
);

  logic [AW-1:0] rr_ptr_q, rr_ptr_d;
  logic          use_rr;

  // Scanning downward lets the lowest free index win the last assignment.
  always_comb begin
    idx    = rr_ptr_q;
    use_rr = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        idx    = AW'(i);
        use_rr = 1'b0;
      end
    end
  end

  assign rr_ptr_d = (advance && use_rr) ? rr_ptr_q + AW'(1) : rr_ptr_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/l1_tlb_refill.sv
// L1 TLB miss handler: forwards one miss at a time to the page-table walker and
// writes the returned leaf PTE into a victim slot of the L1 TLB.
module l1_tlb_refill
  import l1_tlb_refill_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SOURCE     = 0,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [VADDR_SIZE-1:0] miss_vaddr,
  input  logic                  flush,
  input  logic                  fence_busy,
  input  logic [DEPTH-1:0]      tlb_valid,
  output logic                  ptw_req,
  output logic [VADDR_SIZE-1:0] ptw_vaddr,
  output logic [1:0]            ptw_source,
  input  logic                  ptw_ready,
  input  logic                  ptw_rsp_valid,
  input  pte_entry_t            ptw_rsp_entry,
  input  logic [1:0]            ptw_rsp_wpn,
  input  logic                  ptw_rsp_exc,
  output logic                  tlb_we,
  output logic                  tlb_wen,
  output logic [ADDR_WIDTH-1:0] tlb_widx,
  output pte_entry_t            tlb_wentry,
  output logic [1:0]            tlb_wpn,
  output logic [VADDR_SIZE-1:0] tlb_waddr,
  output logic                  busy,
  output logic                  refill_done,
  output logic                  refill_exc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DROP
  } state_e;

  state_e     state_q, state_d;
  vpn_addr_t  vpn_q, vpn_d;
  pte_entry_t entry_q, entry_d;
  logic [1:0] wpn_q, wpn_d;
  logic       exc_q, exc_d;

  logic [ADDR_WIDTH-1:0] victim_idx;
  logic [VADDR_SIZE-1:0] page_vaddr;
  logic                  unused_offset;

  assign unused_offset = ^miss_vaddr[TLB_OFFSET-1:0];
  assign page_vaddr    = {vpn_q, {TLB_OFFSET{1'b0}}};
  assign ptw_source    = 2'(SOURCE);
  assign busy          = (state_q != ST_IDLE);

  tlb_victim_sel #(
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_victim_sel (
    .clk     (clk),
    .rst     (rst),
    .valid   (tlb_valid),
    .advance (tlb_we & tlb_wen),
    .idx     (victim_idx)
  );

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    vpn_d       = vpn_q;
    entry_d     = entry_q;
    wpn_d       = wpn_q;
    exc_d       = exc_q;
    ptw_req     = 1'b0;
    tlb_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_valid && !flush) begin
          vpn_d   = miss_vaddr[VADDR_SIZE-1:TLB_OFFSET];
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A flush suppresses the request outright so the walker never sees a handshake.
        ptw_req = !flush;
        if (flush)          state_d = ST_IDLE;
        else if (ptw_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ptw_rsp_valid ? ST_IDLE : ST_DROP;
        end else if (ptw_rsp_valid) begin
          entry_d = ptw_rsp_entry;
          wpn_d   = ptw_rsp_wpn;
          exc_d   = ptw_rsp_exc;
          state_d = ST_WRITE;
        end
      end
      ST_DROP: begin
        if (ptw_rsp_valid) state_d = ST_IDLE;
      end
      ST_WRITE: begin
        if (!fence_busy) begin
          tlb_we  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write-port data is zeroed outside the strobe so idle outputs stay quiet.
  assign tlb_wen     = tlb_we & ~exc_q;
  assign tlb_widx    = tlb_we ? victim_idx : '0;
  assign tlb_wentry  = tlb_we ? entry_q : '0;
  assign tlb_wpn     = tlb_we ? wpn_q : '0;
  assign tlb_waddr   = tlb_we ? page_vaddr : '0;
  assign refill_done = tlb_we;
  assign refill_exc  = tlb_we & exc_q;
  assign ptw_vaddr   = (state_q == ST_REQ) ? page_vaddr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      vpn_q   <= '0;
      entry_q <= '0;
      wpn_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vpn_q   <= vpn_d;
      entry_q <= entry_d;
      wpn_q   <= wpn_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_l1_tlb_refill.sv
// Directed bench for l1_tlb_refill: fills, round-robin wrap, faults, flushes,
// fence stalls and asynchronous reset.
module tb_l1_tlb_refill;
  import l1_tlb_refill_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  miss_valid;
  logic [VADDR_SIZE-1:0] miss_vaddr;
  logic                  flush;
  logic                  fence_busy;
  logic [DEPTH-1:0]      tlb_valid;
  logic                  ptw_req;
  logic [VADDR_SIZE-1:0] ptw_vaddr;
  logic [1:0]            ptw_source;
  logic                  ptw_ready;
  logic                  ptw_rsp_valid;
  pte_entry_t            ptw_rsp_entry;
  logic [1:0]            ptw_rsp_wpn;
  logic                  ptw_rsp_exc;
  logic                  tlb_we;
  logic                  tlb_wen;
  logic [AW-1:0]         tlb_widx;
  pte_entry_t            tlb_wentry;
  logic [1:0]            tlb_wpn;
  logic [VADDR_SIZE-1:0] tlb_waddr;
  logic                  busy;
  logic                  refill_done;
  logic                  refill_exc;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  l1_tlb_refill #(.DEPTH(DEPTH), .SOURCE(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_vaddr    (miss_vaddr),
    .flush         (flush),
    .fence_busy    (fence_busy),
    .tlb_valid     (tlb_valid),
    .ptw_req       (ptw_req),
    .ptw_vaddr     (ptw_vaddr),
    .ptw_source    (ptw_source),
    .ptw_ready     (ptw_ready),
    .ptw_rsp_valid (ptw_rsp_valid),
    .ptw_rsp_entry (ptw_rsp_entry),
    .ptw_rsp_wpn   (ptw_rsp_wpn),
    .ptw_rsp_exc   (ptw_rsp_exc),
    .tlb_we        (tlb_we),
    .tlb_wen       (tlb_wen),
    .tlb_widx      (tlb_widx),
    .tlb_wentry    (tlb_wentry),
    .tlb_wpn       (tlb_wpn),
    .tlb_waddr     (tlb_waddr),
    .busy          (busy),
    .refill_done   (refill_done),
    .refill_exc    (refill_exc)
  );

  // Counts of handshakes and write strobes seen at the active edge.
  always @(posedge clk) begin
    if (ptw_req && ptw_ready) hs_cnt <= hs_cnt + 1;
    if (tlb_we)               we_cnt <= we_cnt + 1;
  end

  function automatic pte_entry_t mk_pte(input logic [43:0] ppn);
    pte_entry_t p;
    p     = '0;
    p.ppn = ppn;
    p.v   = 1'b1;
    p.r   = 1'b1;
    p.w   = 1'b1;
    p.a   = 1'b1;
    p.d   = 1'b1;
    return p;
  endfunction

  // Full refill: miss, same-cycle ready, response after rsp_delay cycles, then
  // the write cycle (fence idle). Observed values are returned for the caller.
  task automatic fill(input logic [VADDR_SIZE-1:0] va, input logic [DEPTH-1:0] valid,
                      input pte_entry_t pte, input logic [1:0] wpn, input logic exc,
                      input int rsp_delay,
                      output logic o_req, output logic [VADDR_SIZE-1:0] o_vaddr,
                      output logic o_we, output logic o_wen, output logic [AW-1:0] o_widx,
                      output pte_entry_t o_entry, output logic [1:0] o_wpn,
                      output logic [VADDR_SIZE-1:0] o_waddr, output logic o_done,
                      output logic o_exc, output logic o_busy_after);
    tlb_valid = valid;
    @(negedge clk);
    miss_valid = 1'b1;
    miss_vaddr = va;
    @(negedge clk);
    miss_valid = 1'b0;
    ptw_ready  = 1'b1;
    #1;
    o_req   = ptw_req;
    o_vaddr = ptw_vaddr;
    @(negedge clk);
    ptw_ready = 1'b0;
    repeat (rsp_delay - 2) @(negedge clk);
    if (rsp_delay > 1) @(negedge clk);
    ptw_rsp_valid = 1'b1;
    ptw_rsp_entry = pte;
    ptw_rsp_wpn   = wpn;
    ptw_rsp_exc   = exc;
    @(negedge clk);
    ptw_rsp_valid = 1'b0;
    ptw_rsp_entry = '0;
    ptw_rsp_wpn   = '0;
    ptw_rsp_exc   = 1'b0;
    #1;
    o_we    = tlb_we;
    o_wen   = tlb_wen;
    o_widx  = tlb_widx;
    o_entry = tlb_wentry;
    o_wpn   = tlb_wpn;
    o_waddr = tlb_waddr;
    o_done  = refill_done;
    o_exc   = refill_exc;
    @(negedge clk);
    #1;
    o_busy_after = busy | tlb_we;
  endtask

  logic                  r_req, r_we, r_wen, r_done, r_exc, r_busy;
  logic [VADDR_SIZE-1:0] r_vaddr, r_waddr;
  logic [AW-1:0]         r_widx;
  pte_entry_t            r_entry;
  logic [1:0]            r_wpn;

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({ptw_req, busy, tlb_we, tlb_wen, refill_done, refill_exc} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {ptw_req, busy, tlb_we, tlb_wen, refill_done, refill_exc});
    end
    checks++;
    if (ptw_vaddr !== '0 || tlb_widx !== '0 || tlb_waddr !== '0 || tlb_wentry !== '0) begin
      errors++;
      $display("FAIL reset_data: vaddr=%h widx=%0d waddr=%h expected all zero",
               ptw_vaddr, tlb_widx, tlb_waddr);
    end
    checks++;
    if (ptw_source !== 2'd1) begin
      errors++;
      $display("FAIL reset_source: got %0d expected 1", ptw_source);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_fill();
    pte_entry_t pte;
    pte = mk_pte(44'h8_0001);
    fill(39'h00_4000_3123, 16'h00FF, pte, 2'b00, 1'b0, 3,
         r_req, r_vaddr, r_we, r_wen, r_widx, r_entry, r_wpn, r_waddr, r_done, r_exc, r_busy);
    checks++;
    if (r_req !== 1'b1 || r_vaddr !== 39'h00_4000_3000) begin
      errors++;
      $display("FAIL basic_req: req=%b vaddr=%h expected 1 / 0040003000", r_req, r_vaddr);
    end
    checks++;
    if (r_we !== 1'b1 || r_wen !== 1'b1 || r_widx !== 4'd8) begin
      errors++;
      $display("FAIL basic_write: we=%b wen=%b widx=%0d expected 1 1 8", r_we, r_wen, r_widx);
    end
    checks++;
    if (r_entry !== pte || r_wpn !== 2'b00 || r_waddr !== 39'h00_4000_3000) begin
      errors++;
      $display("FAIL basic_data: entry=%h wpn=%b waddr=%h expected %h 00 0040003000",
               r_entry, r_wpn, r_waddr, pte);
    end
    checks++;
    if (r_done !== 1'b1 || r_exc !== 1'b0 || r_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b exc=%b busy_after=%b expected 1 0 0",
               r_done, r_exc, r_busy);
    end
  endtask

  // rr_ptr starts at 0 (basic fill used a free slot), so 17 fills give 0..15,0.
  task automatic test_round_robin();
    for (int i = 0; i < 17; i++) begin
      fill(39'h00_0000_1000 + VADDR_SIZE'(i) * 39'h1000, 16'hFFFF, mk_pte(44'(i)), 2'b01,
           1'b0, 2, r_req, r_vaddr, r_we, r_wen, r_widx, r_entry, r_wpn, r_waddr, r_done,
           r_exc, r_busy);
      checks++;
      if (r_we !== 1'b1 || r_widx !== AW'(i % 16) || r_wpn !== 2'b01) begin
        errors++;
        $display("FAIL rr_fill%0d: we=%b widx=%0d wpn=%b expected 1 %0d 01",
                 i, r_we, r_widx, r_wpn, i % 16);
      end
    end
  endtask

  // rr_ptr is 1 here; a fault must use it without advancing it.
  task automatic test_fault();
    fill(39'h00_7777_7abc, 16'hFFFF, mk_pte(44'h123), 2'b10, 1'b1, 2,
         r_req, r_vaddr, r_we, r_wen, r_widx, r_entry, r_wpn, r_waddr, r_done, r_exc, r_busy);
    checks++;
    if (r_we !== 1'b1 || r_wen !== 1'b0 || r_widx !== 4'd1) begin
      errors++;
      $display("FAIL fault_write: we=%b wen=%b widx=%0d expected 1 0 1", r_we, r_wen, r_widx);
    end
    checks++;
    if (r_done !== 1'b1 || r_exc !== 1'b1) begin
      errors++;
      $display("FAIL fault_flags: done=%b exc=%b expected 1 1", r_done, r_exc);
    end
    fill(39'h00_7777_8000, 16'hFFFF, mk_pte(44'h124), 2'b00, 1'b0, 2,
         r_req, r_vaddr, r_we, r_wen, r_widx, r_entry, r_wpn, r_waddr, r_done, r_exc, r_busy);
    checks++;
    if (r_widx !== 4'd1 || r_wen !== 1'b1 || r_exc !== 1'b0) begin
      errors++;
      $display("FAIL fault_rr_hold: widx=%0d wen=%b exc=%b expected 1 1 0", r_widx, r_wen, r_exc);
    end
  endtask

  task automatic test_flush();
    int hs0, we0;
    hs0 = hs_cnt;
    we0 = we_cnt;
    @(negedge clk);
    miss_valid = 1'b1;
    miss_vaddr = 39'h00_1234_5678;
    @(negedge clk);
    miss_valid = 1'b0;
    flush      = 1'b1;
    ptw_ready  = 1'b1;
    #1;
    checks++;
    if (ptw_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_gate: ptw_req=%b expected 0", ptw_req);
    end
    @(negedge clk);
    flush     = 1'b0;
    ptw_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hs_cnt !== hs0) begin
      errors++;
      $display("FAIL flush_req_idle: busy=%b handshakes=%0d expected 0 %0d", busy, hs_cnt, hs0);
    end
    // Flush while waiting: the late response must be swallowed.
    @(negedge clk);
    miss_valid = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
    ptw_ready  = 1'b1;
    @(negedge clk);
    ptw_ready = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_drop_busy: busy=%b expected 1", busy);
    end
    @(negedge clk);
    ptw_rsp_valid = 1'b1;
    ptw_rsp_entry = mk_pte(44'hBAD);
    #1;
    checks++;
    if (busy !== 1'b1 || tlb_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop_rsp: busy=%b we=%b expected 1 0", busy, tlb_we);
    end
    @(negedge clk);
    ptw_rsp_valid = 1'b0;
    ptw_rsp_entry = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || tlb_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop_idle: busy=%b we=%b expected 0 0", busy, tlb_we);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (we_cnt !== we0 || hs_cnt !== hs0 + 1) begin
      errors++;
      $display("FAIL flush_counts: writes=%0d handshakes=%0d expected %0d %0d",
               we_cnt, hs_cnt, we0, hs0 + 1);
    end
  endtask

  task automatic test_fence_stall();
    int hs0, we0;
    hs0 = hs_cnt;
    we0 = we_cnt;
    tlb_valid = 16'hFFF7;
    @(negedge clk);
    miss_valid = 1'b1;
    miss_vaddr = 39'h00_0abc_d000;
    @(negedge clk);
    miss_valid = 1'b0;
    ptw_ready  = 1'b1;
    @(negedge clk);
    ptw_ready  = 1'b0;
    miss_valid = 1'b1;
    @(negedge clk);
    miss_valid    = 1'b0;
    ptw_rsp_valid = 1'b1;
    ptw_rsp_entry = mk_pte(44'h5555);
    fence_busy    = 1'b1;
    @(negedge clk);
    ptw_rsp_valid = 1'b0;
    ptw_rsp_entry = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (tlb_we !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL fence_hold%0d: we=%b busy=%b expected 0 1", i, tlb_we, busy);
      end
      @(negedge clk);
    end
    fence_busy = 1'b0;
    #1;
    checks++;
    if (tlb_we !== 1'b1 || tlb_widx !== 4'd3 || tlb_waddr !== 39'h00_0abc_d000) begin
      errors++;
      $display("FAIL fence_release: we=%b widx=%0d waddr=%h expected 1 3 000abcd000",
               tlb_we, tlb_widx, tlb_waddr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (we_cnt !== we0 + 1 || hs_cnt !== hs0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fence_counts: writes=%0d handshakes=%0d busy=%b expected %0d %0d 0",
               we_cnt, hs_cnt, busy, we0 + 1, hs0 + 1);
    end
  endtask

  task automatic test_async_reset();
    int we0;
    we0 = we_cnt;
    @(negedge clk);
    miss_valid = 1'b1;
    miss_vaddr = 39'h00_0fed_c000;
    @(negedge clk);
    miss_valid = 1'b0;
    ptw_ready  = 1'b1;
    @(negedge clk);
    ptw_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ptw_req !== 1'b0 || busy !== 1'b0 || tlb_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: req=%b busy=%b we=%b expected 0 0 0", ptw_req, busy, tlb_we);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ptw_rsp_valid = 1'b1;
    ptw_rsp_entry = mk_pte(44'h777);
    @(negedge clk);
    ptw_rsp_valid = 1'b0;
    ptw_rsp_entry = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || tlb_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_stale_rsp: busy=%b we=%b expected 0 0", busy, tlb_we);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (we_cnt !== we0) begin
      errors++;
      $display("FAIL reset_no_write: writes=%0d expected %0d", we_cnt, we0);
    end
  endtask

  initial begin
    miss_valid    = 1'b0;
    miss_vaddr    = '0;
    flush         = 1'b0;
    fence_busy    = 1'b0;
    tlb_valid     = '0;
    ptw_ready     = 1'b0;
    ptw_rsp_valid = 1'b0;
    ptw_rsp_entry = '0;
    ptw_rsp_wpn   = '0;
    ptw_rsp_exc   = 1'b0;
    test_reset();
    test_basic_fill();
    test_round_robin();
    test_fault();
    test_flush();
    test_fence_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
